// File: rtl/inst_fetch_port_pkg.sv
// Shared widths, beat count and IF state encodings for the instruction fetch port.
package inst_fetch_port_pkg;

    localparam int INST_ADDR_W = 32;
    localparam int INST_W      = 32;
    localparam int INST_BYTES  = 4;

    localparam logic [0:0] IF_IDLE  = 1'b0;
    localparam logic [0:0] IF_FETCH = 1'b1;

endpackage

// File: rtl/inst_fetch_port_if.sv
// Byte-wide req/ack memory read bus between the fetch port (master) and memory (slave).
interface inst_fetch_port_if
    import inst_fetch_port_pkg::*;
#(
    parameter int ADDR_W = INST_ADDR_W
);

    logic              req;
    logic [ADDR_W-1:0] addr;
    logic [7:0]        rdata;
    logic              ack;

    modport master (output req, output addr, input rdata, input ack);
    modport slave  (input req, input addr, output rdata, output ack);

endinterface

// File: rtl/inst_fetch_port.sv
// Responder side of the PC fetch interface: assembles each instruction word from
// BYTES little-endian memory beats and keeps the last word in a one-entry buffer.
module inst_fetch_port
    import inst_fetch_port_pkg::*;
#(
    parameter int ADDR_W = INST_ADDR_W,
    parameter int BYTES  = INST_BYTES
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ce_i,
    input  logic [ADDR_W-1:0] pc_i,
    output logic [INST_W-1:0] inst_o,
    output logic              stallreq_o,
    inst_fetch_port_if.master mem
);

    localparam int CNT_W = (BYTES > 1) ? $clog2(BYTES) : 1;
    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BYTES - 1);

    logic [0:0]        state;
    logic [CNT_W-1:0]  beat_cnt;
    logic [ADDR_W-1:0] fetch_addr;
    logic              buf_valid;
    logic [ADDR_W-1:0] buf_addr;
    logic [INST_W-1:0] buf_data;
    logic              mem_req;
    logic              hit;
    logic              beat_done;

    assign hit        = ce_i & buf_valid & (buf_addr == pc_i);
    assign inst_o     = hit ? buf_data : '0;
    assign stallreq_o = ce_i & ~hit;

    assign beat_done  = mem_req & mem.ack;
    assign mem.req    = mem_req;
    assign mem.addr   = fetch_addr + ADDR_W'(beat_cnt);

    // A burst, once started, always runs to completion so the bus never sees a
    // dropped request; a pc change is handled as a fresh miss afterwards.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IF_IDLE;
            beat_cnt   <= '0;
            fetch_addr <= '0;
            buf_valid  <= 1'b0;
            buf_addr   <= '0;
            buf_data   <= '0;
            mem_req    <= 1'b0;
        end else begin
            case (state)
                IF_IDLE: begin
                    if (ce_i && !hit) begin
                        state      <= IF_FETCH;
                        fetch_addr <= pc_i;
                        beat_cnt   <= '0;
                        buf_valid  <= 1'b0;
                        mem_req    <= 1'b1;
                    end
                end
                IF_FETCH: begin
                    if (beat_done) begin
                        buf_data[{beat_cnt, 3'b000} +: 8] <= mem.rdata;
                        beat_cnt <= beat_cnt + 1'b1;
                        if (beat_cnt == LAST_BEAT) begin
                            buf_addr  <= fetch_addr;
                            buf_valid <= 1'b1;
                            mem_req   <= 1'b0;
                            beat_cnt  <= '0;
                            state     <= IF_IDLE;
                        end
                    end
                end
                default: begin
                    state   <= IF_IDLE;
                    mem_req <= 1'b0;
                end
            endcase
        end
    end

endmodule
